// File: rtl/input_debouncer.sv
// Two-flop synchronizer plus stability-counting FSM producing a clean level and edge strobes.
// Define DEBOUNCE_FALL_EDGE_EN to add the FALL strobe port.
module input_debouncer #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 3
) (
    input  logic CLK,
    input  logic CLR,
    input  logic D_RAW,
    output logic Q,
    output logic RISE
`ifdef DEBOUNCE_FALL_EDGE_EN
    ,
    output logic FALL
`endif
);

    localparam logic [1:0] StIdleLow  = 2'd0;
    localparam logic [1:0] StWaitHigh = 2'd1;
    localparam logic [1:0] StIdleHigh = 2'd2;
    localparam logic [1:0] StWaitLow  = 2'd3;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
`ifdef DEBOUNCE_FALL_EDGE_EN
    logic             fall_q, fall_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
`ifdef DEBOUNCE_FALL_EDGE_EN
        fall_d  = 1'b0;
`endif
        case (state_q)
            StIdleLow: begin
                if (s2_q) begin
                    state_d = StWaitHigh;
                    cnt_d   = CntOne;
                end
            end
            StWaitHigh: begin
                // Any low sample is a bounce: abandon the partial count entirely.
                if (!s2_q) begin
                    state_d = StIdleLow;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = StIdleHigh;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StIdleHigh: begin
                if (!s2_q) begin
                    state_d = StWaitLow;
                    cnt_d   = CntOne;
                end
            end
            StWaitLow: begin
                if (s2_q) begin
                    state_d = StIdleHigh;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = StIdleLow;
                    level_d = 1'b0;
`ifdef DEBOUNCE_FALL_EDGE_EN
                    fall_d  = 1'b1;
`endif
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = StIdleLow;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!CLR) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= StIdleLow;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
`ifdef DEBOUNCE_FALL_EDGE_EN
            fall_q  <= 1'b0;
`endif
        end else begin
            s1_q    <= D_RAW;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
`ifdef DEBOUNCE_FALL_EDGE_EN
            fall_q  <= fall_d;
`endif
        end
    end

    assign Q    = level_q;
    assign RISE = rise_q;
`ifdef DEBOUNCE_FALL_EDGE_EN
    assign FALL = fall_q;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: directed vector table, reset-mid-wait sequence and random
// bouncing stimulus checked against a sample-window reference model.
module tb_input_debouncer;

    localparam int S = 4;

    logic CLK = 1'b0;
    logic CLR = 1'b0;
    logic D_RAW = 1'b0;
    logic Q, RISE;
`ifdef DEBOUNCE_FALL_EDGE_EN
    logic FALL;
`endif

    int n_vec = 0;
    int n_err = 0;

    input_debouncer #(
        .STABLE_CYCLES(S),
        .CNT_W(3)
    ) dut (
        .CLK(CLK),
        .CLR(CLR),
        .D_RAW(D_RAW),
        .Q(Q),
        .RISE(RISE)
`ifdef DEBOUNCE_FALL_EDGE_EN
        ,
        .FALL(FALL)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic  clr;
        logic  d;
        logic  exp_q;
        logic  exp_rise;
        logic  exp_fall;
        string name;
    } vec_t;

    vec_t vecs[$];

    // Model: history of D_RAW values sampled at each edge (newest last). The FSM at an edge sees
    // the sample taken two edges earlier; Q flips once the last S such samples all differ from Q.
    bit hist[$];
    bit m_q, m_rise, m_fall;

    task automatic model_edge(input logic clr, input logic d);
        bit all_diff;
        if (!clr) begin
            hist = {};
            for (int i = 0; i < S + 1; i++) hist.push_back(1'b0);
            m_q = 1'b0;
            m_rise = 1'b0;
            m_fall = 1'b0;
        end else begin
            all_diff = 1'b1;
            for (int k = 0; k < S; k++) begin
                if (hist[hist.size() - 2 - k] == m_q) all_diff = 1'b0;
            end
            m_rise = all_diff && !m_q;
            m_fall = all_diff && m_q;
            if (all_diff) m_q = !m_q;
            hist.push_back(d);
            void'(hist.pop_front());
        end
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, take one rising edge, compare #1 later.
    task automatic step(input logic clr, input logic d);
        CLR = clr;
        D_RAW = d;
        @(posedge CLK);
        model_edge(clr, d);
        #1;
        check("model_q", Q, m_q);
        check("model_rise", RISE, m_rise);
`ifdef DEBOUNCE_FALL_EDGE_EN
        check("model_fall", FALL, m_fall);
`endif
        @(negedge CLK);
    endtask

    function automatic void add(input logic clr, input logic d, input logic q, input logic r,
                                input logic f, input string name);
        vec_t v;
        v.clr = clr; v.d = d; v.exp_q = q; v.exp_rise = r; v.exp_fall = f; v.name = name;
        vecs.push_back(v);
    endfunction

    initial begin
        int lat;
        for (int i = 0; i < S + 1; i++) hist.push_back(1'b0);

        // Reset with D_RAW high, then release and hold high.
        add(0, 1, 0, 0, 0, "reset");
        add(0, 1, 0, 0, 0, "reset");
        for (int i = 0; i < 5; i++) add(1, 1, 0, 0, 0, "press_wait");
        add(1, 1, 1, 1, 0, "press_accept");
        add(1, 1, 1, 0, 0, "press_hold");
        // Release.
        for (int i = 0; i < 5; i++) add(1, 0, 1, 0, 0, "release_wait");
        add(1, 0, 0, 0, 1, "release_accept");
        add(1, 0, 0, 0, 0, "release_hold");
        // Three-sample glitch.
        for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 0, "glitch_high");
        for (int i = 0; i < 6; i++) add(1, 0, 0, 0, 0, "glitch_low");
        // Bounce 1,0,1,0 then stable high.
        add(1, 1, 0, 0, 0, "bounce");
        add(1, 0, 0, 0, 0, "bounce");
        add(1, 1, 0, 0, 0, "bounce");
        add(1, 0, 0, 0, 0, "bounce");
        for (int i = 0; i < 5; i++) add(1, 1, 0, 0, 0, "bounce_settle");
        add(1, 1, 1, 1, 0, "bounce_accept");
        add(1, 1, 1, 0, 0, "bounce_hold");

        @(negedge CLK);
        foreach (vecs[i]) begin
            step(vecs[i].clr, vecs[i].d);
            check({vecs[i].name, "_q"}, Q, vecs[i].exp_q);
            check({vecs[i].name, "_rise"}, RISE, vecs[i].exp_rise);
`ifdef DEBOUNCE_FALL_EDGE_EN
            check({vecs[i].name, "_fall"}, FALL, vecs[i].exp_fall);
`endif
        end

        // Reset while counting up in the high-wait state.
        repeat (8) step(1, 0);
        repeat (4) step(1, 1);
        check_int("midwait_cnt_before", int'(dut.cnt_q), 2);
        step(0, 1);
        check_int("midwait_cnt_cleared", int'(dut.cnt_q), 0);
        check("midwait_q_cleared", Q, 1'b0);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1, 1);
            if (Q === 1'b1) begin
                lat = i;
                break;
            end
        end
        check_int("midwait_latency", lat, 6);

        // Random bouncing runs with occasional resets.
        for (int n = 0; n < 3000; ) begin
            int len;
            logic v;
            len = $urandom_range(1, 7);
            v = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) step(($urandom_range(0, 99) != 0), v);
            n += len;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Input conditioning stage that sits directly upstream of the team's clocked D flip-flop / register stages.
- Takes a raw, asynchronous, bouncing single-bit input (switch or button), synchronizes it, filters it, and produces a clean level Q suitable for driving a flip-flop D input.
- Also produces a one-cycle RISE strobe for downstream counters and FSMs.

Parameters:
- STABLE_CYCLES, 4, number of consecutive identical synchronized samples required to accept a new level; legal range 2..(2^CNT_W - 1).
- CNT_W, 3, width of the internal stability counter.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- CLR  input  1  reset, synchronous, active-low; sampled on the rising edge of CLK.
- D_RAW  input  1  raw asynchronous input.
- Q  output  1  debounced level, registered.
- RISE  output  1  one-cycle pulse, registered, on each accepted 0->1 transition of Q.
- FALL  output  1  one-cycle pulse on each accepted 1->0 transition of Q; present only with DEBOUNCE_FALL_EDGE_EN.

Behaviour:
- Reset: when CLR=0 at a CLK edge, the following are cleared to their reset values:
  - s1=0, s2=0, cnt=0
  - state=IDLE_LOW
  - Q=0, RISE=0, FALL=0
- Reset has priority over all other behaviour.
- Reset mid-WAIT discards any partial count. No pulse is generated by reset, even if Q was 1.
- Synchronizer: two-flop chain with s1<=D_RAW and s2<=s1. The FSM uses only s2.
- States: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW. Encoding is free.
- IDLE_LOW:
  - s2=1 -> WAIT_HIGH, cnt<=1.
  - Otherwise hold.
- WAIT_HIGH:
  - s2=0 -> IDLE_LOW, cnt<=0. Q stays 0 and no pulse is generated.
  - s2=1 and cnt==STABLE_CYCLES-1 -> IDLE_HIGH, Q<=1, RISE<=1, cnt<=0.
  - s2=1 otherwise -> cnt<=cnt+1.
- IDLE_HIGH:
  - s2=0 -> WAIT_LOW, cnt<=1.
  - Otherwise hold.
- WAIT_LOW: mirror of WAIT_HIGH with the polarity of s2 inverted.
  - On acceptance: Q<=0, FALL<=1 (when enabled).
- Pulses: RISE and FALL default to 0 every cycle and are high for exactly one cycle, coincident with the cycle in which Q first shows its new value.
- Latency: let edge 1 be the first CLK edge that samples D_RAW=1, with the input held stable afterwards.
  - s2=1 after edge 2.
  - Q=1 and RISE=1 after edge STABLE_CYCLES+2.
  - RISE=0 after edge STABLE_CYCLES+3.
  - Falling latency is identical.
- Glitch rule: any s2 pulse shorter than STABLE_CYCLES consecutive samples never changes Q.
- A bounce during WAIT returns the FSM to the IDLE state and restarts counting from scratch.
- Counter: cnt never exceeds STABLE_CYCLES-1 and never wraps.
- Outputs change only on CLK edges. There is no combinational path from D_RAW to any output.

Optional Feature:
- Macro: DEBOUNCE_FALL_EDGE_EN.
- Defined:
  - FALL port exists.
  - FALL pulses for one cycle when Q goes 1->0, with the same timing as RISE.
- Undefined:
  - FALL port is absent.
  - The WAIT_LOW -> IDLE_LOW transition still clears Q.
  - Q, RISE and all other timing are unchanged.

Test Plan:
- Reset: CLR=0 for 2 edges with D_RAW=1, then CLR=1 -> Q=0 and RISE=0 throughout reset; with D_RAW held at 1, Q=1 after the 6th edge following CLR release.
- Clean press (STABLE_CYCLES=4, 10 ns clock): D_RAW 0->1 at t=12 and held -> Q=1 and RISE=1 after the edge at t=65; RISE=0 after the edge at t=75; exactly one RISE pulse in total.
- Bounce: D_RAW toggles 1,0,1,0 every 10 ns, then holds 1 -> no RISE during toggling; Q=1 exactly 6 edges after the first stable-high sample; one RISE pulse.
- Short glitch: D_RAW high for 30 ns (3 samples), then low -> Q stays 0 and RISE is never asserted.
- Release: from Q=1, D_RAW 1->0 held -> Q=0 after 6 edges; RISE stays 0; FALL pulses once if DEBOUNCE_FALL_EDGE_EN is defined.
- Reset mid-wait: CLR=0 for one edge while in WAIT_HIGH with cnt=2 -> Q=0 and cnt=0; after release the full 6-edge latency applies again.
